// File: rtl/vx_pipeline_perf_ctrl.sv
// ---------------------------------------------------------------------------
// vx_pipeline_perf_ctrl
//
// Owns the pipeline performance counters: scheduler idle, scheduler stall,
// ibuffer stall, scoreboard stall, and one usage counter per execute unit.
// Each counter is a wrap-around accumulator of its per-cycle event bit.
// The CSR/DCR side reaches the counters through one request/response port
// that supports single-counter read, a sequenced clear-all sweep (one
// counter per cycle) and an optional atomic snapshot.
//
// Optional feature macro: PERF_SNAPSHOT_EN
//   defined   -> snapshot bank present; op 10 captures all counters, reads
//                return the snapshot bank
//   undefined -> no snapshot bank; op 10 answers with an error, reads
//                return the live counters
//
// Ports
//   i_clk        core clock, all state changes on the rising edge
//   i_reset      synchronous active-high reset
//   i_enable     counting gate (commands are served regardless)
//   i_events     per-cycle event bits, one per counter
//   i_req_valid  command valid
//   o_req_ready  command accepted on i_req_valid & o_req_ready
//   i_req_op     00 read, 01 clear-all, 10 snapshot, 11 reserved
//   i_req_addr   counter index for read
//   o_rsp_valid  response valid
//   i_rsp_ready  response consumed on o_rsp_valid & i_rsp_ready
//   o_rsp_data   read value (0 for non-read ops and errors)
//   o_rsp_error  bad op or bad address
// ---------------------------------------------------------------------------
module vx_pipeline_perf_ctrl #(
  parameter  int NUM_UNITS = 4,
  parameter  int CTR_W     = 44,
  localparam int NUM_CTRS  = 4 + NUM_UNITS,
  localparam int AW        = $clog2(NUM_CTRS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NUM_CTRS-1:0] i_events,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [1:0]          i_req_op,
  input  logic [AW-1:0]       i_req_addr,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [CTR_W-1:0]    o_rsp_data,
  output logic                o_rsp_error
);

  localparam logic [1:0]    OP_READ  = 2'b00;
  localparam logic [1:0]    OP_CLEAR = 2'b01;
  localparam logic [1:0]    OP_SNAP  = 2'b10;
  localparam logic [AW:0]   NUM_CTRS_W = (AW+1)'(NUM_CTRS);
  localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_CTRS - 1);

`ifdef PERF_SNAPSHOT_EN
  localparam logic SNAP_ERR = 1'b0;
`else
  localparam logic SNAP_ERR = 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RSP
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_clr_idx;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [CTR_W-1:0] r_rsp_data;
  logic             r_rsp_error;
  logic [CTR_W-1:0] r_ctr [NUM_CTRS];

  logic             w_accept;
  logic             w_addr_bad;
  logic [CTR_W-1:0] w_read_val;

  assign w_accept   = i_req_valid & r_req_ready;
  // Widen the address by one bit so the range check also works when
  // NUM_CTRS is an exact power of two.
  assign w_addr_bad = ({1'b0, i_req_addr} >= NUM_CTRS_W);

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_error = r_rsp_error;

  // Live counters. The clear sweep zeroes exactly one counter per cycle and
  // takes priority over that counter's event; every other counter keeps
  // counting whenever enable and its event bit are high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_ctr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        if (r_state == CLEAR && r_clr_idx == AW'(i)) begin
          r_ctr[i] <= '0;
        end else if (i_enable && i_events[i]) begin
          r_ctr[i] <= r_ctr[i] + CTR_W'(1);
        end
      end
    end
  end

`ifdef PERF_SNAPSHOT_EN
  logic [CTR_W-1:0] r_snap [NUM_CTRS];

  // Snapshot bank captures the pre-increment value of every live counter in
  // the accept cycle of a snapshot op. Clear-all leaves it alone.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_snap[i] <= '0;
      end
    end else if (w_accept && i_req_op == OP_SNAP) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        r_snap[i] <= r_ctr[i];
      end
    end
  end
`endif

  // Source of read data: the snapshot bank when present, otherwise the live
  // counters. Out-of-range addresses read as zero.
  always_comb begin
    w_read_val = '0;
    if (!w_addr_bad) begin
`ifdef PERF_SNAPSHOT_EN
      w_read_val = r_snap[i_req_addr];
`else
      w_read_val = r_ctr[i_req_addr];
`endif
    end
  end

  // Command FSM. All handshake outputs are registered so they change only
  // on the clock edge. Reads and single-cycle ops respond one cycle after
  // accept; clear-all walks every counter before responding. The response
  // is held until consumed, and a new command is only taken back in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_clr_idx   <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (i_req_op == OP_CLEAR) begin
              r_clr_idx <= '0;
              r_state   <= CLEAR;
            end else begin
              r_state     <= RSP;
              r_rsp_valid <= 1'b1;
              case (i_req_op)
                OP_READ: begin
                  r_rsp_data  <= w_read_val;
                  r_rsp_error <= w_addr_bad;
                end
                OP_SNAP: begin
                  r_rsp_data  <= '0;
                  r_rsp_error <= SNAP_ERR;
                end
                default: begin
                  r_rsp_data  <= '0;
                  r_rsp_error <= 1'b1;
                end
              endcase
            end
          end
        end
        CLEAR: begin
          if (r_clr_idx == LAST_IDX) begin
            r_state     <= RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + AW'(1);
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vx_pipeline_perf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vx_pipeline_perf_ctrl
//
// Self-checking bench for vx_pipeline_perf_ctrl. The main instance uses the
// default configuration and is compared against a counter-array model that
// applies the counting, clear-sweep schedule and snapshot rules directly.
// A second small instance (7 counters, 4-bit width) exercises counter
// wrap-around and the out-of-range address error.
// Follows PERF_SNAPSHOT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_vx_pipeline_perf_ctrl;

  localparam int NC  = 8;
  localparam int AW  = 3;
  localparam int CW  = 44;
  localparam int NC2 = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NC-1:0] events;
  logic          reqValid;
  logic          reqReady;
  logic [1:0]    reqOp;
  logic [AW-1:0] reqAddr;
  logic          rspValid;
  logic          rspReady;
  logic [CW-1:0] rspData;
  logic          rspError;

  logic           bReset;
  logic           bEnable;
  logic [NC2-1:0] bEvents;
  logic           bReqValid;
  logic           bReqReady;
  logic [1:0]     bReqOp;
  logic [2:0]     bReqAddr;
  logic           bRspValid;
  logic           bRspReady;
  logic [3:0]     bRspData;
  logic           bRspError;

  // Reference model state
  logic [63:0] mCtr  [NC];
  logic [63:0] mSnap [NC];
  logic [63:0] mask = (64'd1 << CW) - 64'd1;
  int          cyc = 0;
  int          clrStart = 0;
  bit          clrActive = 1'b0;
  bit          evMode = 1'b0;
  logic [NC-1:0] evFixed = '0;

  int checkCount = 0;
  int passCount  = 0;

  vx_pipeline_perf_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_events(events),
    .i_req_valid(reqValid), .o_req_ready(reqReady), .i_req_op(reqOp),
    .i_req_addr(reqAddr), .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_data(rspData), .o_rsp_error(rspError)
  );

  vx_pipeline_perf_ctrl #(.NUM_UNITS(3), .CTR_W(4)) dut2 (
    .i_clk(clk), .i_reset(bReset), .i_enable(bEnable), .i_events(bEvents),
    .i_req_valid(bReqValid), .o_req_ready(bReqReady), .i_req_op(bReqOp),
    .i_req_addr(bReqAddr), .o_rsp_valid(bRspValid), .i_rsp_ready(bRspReady),
    .o_rsp_data(bRspData), .o_rsp_error(bRspError)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Model of one clock edge: reset zeroes everything; counter i is zeroed
  // at the (i+1)th edge after the clear accept; otherwise it counts.
  task automatic modelStep();
    if (reset) begin
      for (int i = 0; i < NC; i++) begin
        mCtr[i]  = 64'd0;
        mSnap[i] = 64'd0;
      end
      clrActive = 1'b0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (clrActive && cyc == clrStart + 1 + i) mCtr[i] = 64'd0;
        else if (enable && events[i]) mCtr[i] = (mCtr[i] + 64'd1) & mask;
      end
      if (clrActive && cyc >= clrStart + NC) clrActive = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    cyc++;
    #1;
  endtask

  task automatic randEvents();
    if (evMode) begin
      enable = 1'b1;
      events = evFixed;
    end else begin
      enable = ($urandom_range(0, 3) != 0);
      events = NC'($urandom);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      randEvents();
      tick();
    end
  endtask

  task automatic finishRsp();
    rspReady = 1'b1;
    randEvents();
    tick();
    rspReady = 1'b0;
    checkOutput("rsp_drop", rspValid, 1'b0);
    checkOutput("ready_back", reqReady, 1'b1);
  endtask

  task automatic doRead(input int addr, input int hold);
    logic [63:0] exp;
    checkOutput("rd_ready", reqReady, 1'b1);
    reqValid = 1'b1;
    reqOp    = 2'b00;
    reqAddr  = AW'(addr);
    randEvents();
`ifdef PERF_SNAPSHOT_EN
    exp = mSnap[addr];
`else
    exp = mCtr[addr];
`endif
    tick();
    reqValid = 1'b0;
    reqOp    = 2'($urandom);
    checkOutput("rd_valid", rspValid, 1'b1);
    checkOutput($sformatf("rd_data[%0d]", addr), rspData, exp);
    checkOutput("rd_error", rspError, 1'b0);
    if (hold > 0) begin
      applyStimulus(hold);
      checkOutput("hold_valid", rspValid, 1'b1);
      checkOutput("hold_data", rspData, exp);
    end
    finishRsp();
  endtask

  task automatic doOp(input logic [1:0] op);
    logic expErr;
    checkOutput("op_ready", reqReady, 1'b1);
    reqValid = 1'b1;
    reqOp    = op;
    randEvents();
`ifdef PERF_SNAPSHOT_EN
    expErr = (op == 2'b11);
    if (op == 2'b10) for (int i = 0; i < NC; i++) mSnap[i] = mCtr[i];
`else
    expErr = 1'b1;
`endif
    tick();
    reqValid = 1'b0;
    checkOutput("op_valid", rspValid, 1'b1);
    checkOutput($sformatf("op%0d_data", op), rspData, 64'd0);
    checkOutput($sformatf("op%0d_error", op), rspError, expErr);
    finishRsp();
  endtask

  task automatic startClear();
    reqValid = 1'b1;
    reqOp    = 2'b01;
    randEvents();
    clrStart  = cyc;
    clrActive = 1'b1;
    tick();
    reqValid = 1'b0;
  endtask

  task automatic doClear();
    checkOutput("clr_ready", reqReady, 1'b1);
    startClear();
    for (int k = 1; k <= NC; k++) begin
      checkOutput("clr_busy", {reqReady, rspValid}, 2'b00);
      randEvents();
      tick();
    end
    checkOutput("clr_valid", rspValid, 1'b1);
    checkOutput("clr_data", rspData, 64'd0);
    checkOutput("clr_error", rspError, 1'b0);
    finishRsp();
  endtask

  task automatic doReset();
    reset = 1'b1;
    randEvents();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic readB(input int addr, input logic [3:0] expData, input logic expErr);
`ifdef PERF_SNAPSHOT_EN
    bReqValid = 1'b1;
    bReqOp    = 2'b10;
    tick();
    bReqValid = 1'b0;
    bRspReady = 1'b1;
    tick();
    bRspReady = 1'b0;
`endif
    bReqValid = 1'b1;
    bReqOp    = 2'b00;
    bReqAddr  = 3'(addr);
    tick();
    bReqValid = 1'b0;
    checkOutput("b_valid", bRspValid, 1'b1);
    checkOutput($sformatf("b_data[%0d]", addr), bRspData, expData);
    checkOutput($sformatf("b_error[%0d]", addr), bRspError, expErr);
    bRspReady = 1'b1;
    tick();
    bRspReady = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; events = '0;
    reqValid = 1'b0; reqOp = 2'b00; reqAddr = '0; rspReady = 1'b0;
    bReset = 1'b1; bEnable = 1'b0; bEvents = '0;
    bReqValid = 1'b0; bReqOp = 2'b00; bReqAddr = '0; bRspReady = 1'b0;
    for (int i = 0; i < NC; i++) begin
      mCtr[i] = 64'd0;
      mSnap[i] = 64'd0;
    end
    tick(); tick(); tick();
    reset = 1'b0; bReset = 1'b0;

    checkOutput("rst_req_ready", reqReady, 1'b1);
    checkOutput("rst_rsp_valid", rspValid, 1'b0);
    checkOutput("rst_rsp_data", rspData, 64'd0);
    checkOutput("rst_rsp_error", rspError, 1'b0);

    // Ten sched_idle events, then read counter 0
    evMode = 1'b1; evFixed = NC'(1);
    applyStimulus(10);
    evFixed = '0;
    doRead(0, 0);

    // Reserved op and snapshot op
    doOp(2'b11);
    evFixed = NC'(8);
    applyStimulus(5);
    doOp(2'b10);
    applyStimulus(4);
    doRead(3, 0);

    // Clear-all with every event high, then read counters 0 and 7
    evFixed = '1;
    applyStimulus(6);
    doClear();
    doRead(0, 0);
    doRead(7, 0);

    // Response held for 20 cycles while counter 1 keeps counting
    evFixed = NC'(2);
    applyStimulus(3);
    doOp(2'b10);
    doRead(1, 20);
    doOp(2'b10);
    doRead(1, 0);

    // Reset in the middle of a clear sweep
    evMode = 1'b0;
    applyStimulus(5);
    startClear();
    applyStimulus(3);
    reset = 1'b1;
    randEvents();
    tick();
    reset = 1'b0;
    checkOutput("midclr_ready", reqReady, 1'b1);
    checkOutput("midclr_valid", rspValid, 1'b0);
    checkOutput("midclr_data", rspData, 64'd0);
    applyStimulus(4);
    doOp(2'b10);
    doRead(5, 0);

    // Randomised command mix
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 4)      doRead($urandom_range(0, NC-1), $urandom_range(0, 3));
      else if (r == 5) doClear();
      else if (r == 6) doOp(2'b11);
      else if (r == 7) doOp(2'b10);
      else             applyStimulus($urandom_range(1, 5));
    end

    // Small instance: 19 events on a 4-bit counter wrap to 3; addr 7 is invalid
    bEnable = 1'b1;
    bEvents = NC2'(4);
    repeat (19) tick();
    bEvents = '0;
    readB(2, 4'd3, 1'b0);
    readB(7, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
